// File: rtl/seg_execute_mdu_if.sv
// ID/EX-side inputs and EX/MEM-side outputs of the EX stage, grouped as one bus.
// The stage itself connects through the slave modport; upstream logic drives through master.
interface seg_execute_mdu_if #(
  parameter int NB_ADDR    = 32,
  parameter int NB_DATA    = 32,
  parameter int NB_REG     = 5,
  parameter int NB_CTRL_WB = 2,
  parameter int NB_CTRL_M  = 3,
  parameter int NB_CTRL_EX = 4
);
  logic                                     i_valid;
  logic                                     i_flush;
  logic [NB_ADDR-1:0]                       i_PC;
  logic [NB_DATA-1:0]                       i_read_data_1;
  logic [NB_DATA-1:0]                       i_read_data_2;
  logic [NB_DATA-1:0]                       i_imm;
  logic [NB_REG-1:0]                        i_rt;
  logic [NB_REG-1:0]                        i_rd;
  logic [NB_CTRL_EX+NB_CTRL_M+NB_CTRL_WB-1:0] i_control;
  logic [1:0]                               i_fwd_a;
  logic [1:0]                               i_fwd_b;
  logic [NB_DATA-1:0]                       i_fwd_mem_data;
  logic [NB_DATA-1:0]                       i_fwd_wb_data;

  logic                                     o_stall;
  logic                                     o_valid;
  logic [NB_ADDR-1:0]                       o_PC;
  logic [NB_DATA-1:0]                       o_ALU_result;
  logic                                     o_ALU_zero;
  logic [NB_DATA-1:0]                       o_read_data_2;
  logic [NB_REG-1:0]                        o_write_reg;
  logic [NB_CTRL_M+NB_CTRL_WB-1:0]          o_control;
  logic [NB_DATA-1:0]                       o_hi;
  logic [NB_DATA-1:0]                       o_lo;

  modport slave (
    input  i_valid, i_flush, i_PC, i_read_data_1, i_read_data_2, i_imm, i_rt, i_rd,
           i_control, i_fwd_a, i_fwd_b, i_fwd_mem_data, i_fwd_wb_data,
    output o_stall, o_valid, o_PC, o_ALU_result, o_ALU_zero, o_read_data_2,
           o_write_reg, o_control, o_hi, o_lo
  );

  modport master (
    output i_valid, i_flush, i_PC, i_read_data_1, i_read_data_2, i_imm, i_rt, i_rd,
           i_control, i_fwd_a, i_fwd_b, i_fwd_mem_data, i_fwd_wb_data,
    input  o_stall, o_valid, o_PC, o_ALU_result, o_ALU_zero, o_read_data_2,
           o_write_reg, o_control, o_hi, o_lo
  );
endinterface

// File: rtl/seg_execute_mdu.sv
// MIPS EX stage: forwarding muxes, single-cycle ALU, iterative MULT/DIV unit with
// HI/LO, and the EX/MEM pipeline register. Stalls upstream while the MDU iterates.
module seg_execute_mdu #(
  parameter int NB_ADDR    = 32,
  parameter int NB_DATA    = 32,
  parameter int NB_REG     = 5,
  parameter int NB_CTRL_WB = 2,
  parameter int NB_CTRL_M  = 3,
  parameter int NB_CTRL_EX = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  seg_execute_mdu_if.slave bus
);
  localparam int NB_CTRL_MWB = NB_CTRL_M + NB_CTRL_WB;
  localparam int NB_CTRL     = NB_CTRL_EX + NB_CTRL_MWB;
  localparam int NB_CNT      = $clog2(NB_DATA);
  localparam logic [NB_CNT-1:0] LAST_STEP = NB_CNT'(NB_DATA - 1);

  localparam logic [5:0] F_ADD  = 6'b100000, F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010, F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100, F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110, F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010, F_SLTU = 6'b101011;
  localparam logic [5:0] F_SLL  = 6'b000000, F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_MFHI = 6'b010000, F_MFLO = 6'b010010;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

  // MDU state and the instruction held while it iterates
  state_t                   r_state;
  logic [NB_CNT-1:0]        r_count;
  logic [2*NB_DATA-1:0]     r_prod;
  logic [NB_DATA-1:0]       r_mcand;
  logic [NB_DATA-1:0]       r_raw_a;
  logic                     r_md_div, r_md_signed, r_neg_a, r_neg_b, r_b_zero;
  logic [NB_DATA-1:0]       r_hi, r_lo;
  logic [NB_ADDR-1:0]       r_h_pc;
  logic [NB_DATA-1:0]       r_h_rd2;
  logic [NB_REG-1:0]        r_h_wreg;
  logic [NB_CTRL_MWB-1:0]   r_h_ctrl;

  // EX/MEM register
  logic                     r_valid, r_zero;
  logic [NB_ADDR-1:0]       r_pc;
  logic [NB_DATA-1:0]       r_result, r_rd2;
  logic [NB_REG-1:0]        r_wreg;
  logic [NB_CTRL_MWB-1:0]   r_ctrl;

  logic                     w_alu_src, w_reg_dst;
  logic [1:0]               w_alu_op;
  logic [NB_CTRL_MWB-1:0]   w_ctrl_mwb;
  logic [5:0]               w_funct;
  logic [4:0]               w_shamt;
  logic [NB_DATA-1:0]       w_op_a, w_fwd_b, w_alu_b, w_alu_result;
  logic [NB_REG-1:0]        w_write_reg;
  logic                     w_is_mdu, w_mdu_start, w_stall, w_live;
  logic                     w_signed_in, w_neg_a_in, w_neg_b_in;
  logic [NB_DATA-1:0]       w_mag_a, w_mag_b;
  logic [NB_DATA:0]         w_mul_sum, w_rem_sh, w_div_diff;
  logic                     w_div_ge;
  logic [2*NB_DATA-1:0]     w_mul_next, w_div_next, w_prod_fin;
  logic                     w_neg_res;
  logic [NB_DATA-1:0]       w_quot_fin, w_rem_fin, w_hi_new, w_lo_new;

  function automatic logic [NB_DATA-1:0] fwd_sel(input logic [1:0] sel,
                                                 input logic [NB_DATA-1:0] rf, mem, wb);
    case (sel)
      2'b01:   return wb;
      2'b10:   return mem;
      default: return rf;
    endcase
  endfunction

  assign w_alu_src  = bus.i_control[NB_CTRL-1];
  assign w_alu_op   = bus.i_control[NB_CTRL-2 -: 2];
  assign w_reg_dst  = bus.i_control[NB_CTRL-4];
  assign w_ctrl_mwb = bus.i_control[NB_CTRL_MWB-1:0];
  assign w_funct    = bus.i_imm[5:0];
  assign w_shamt    = bus.i_imm[10:6];

  assign w_op_a      = fwd_sel(bus.i_fwd_a, bus.i_read_data_1, bus.i_fwd_mem_data, bus.i_fwd_wb_data);
  assign w_fwd_b     = fwd_sel(bus.i_fwd_b, bus.i_read_data_2, bus.i_fwd_mem_data, bus.i_fwd_wb_data);
  assign w_alu_b     = w_alu_src ? bus.i_imm : w_fwd_b;
  assign w_write_reg = w_reg_dst ? bus.i_rd : bus.i_rt;

  always_comb begin
    // NOTE: default first so every path assigns the result and no latch is inferred.
    w_alu_result = '0;
    case (w_alu_op)
      2'b00: w_alu_result = w_op_a + w_alu_b;
      2'b01: w_alu_result = w_op_a - w_alu_b;
      2'b11: w_alu_result = w_op_a | w_alu_b;
      default: begin
        case (w_funct)
          F_ADD, F_ADDU: w_alu_result = w_op_a + w_alu_b;
          F_SUB, F_SUBU: w_alu_result = w_op_a - w_alu_b;
          F_AND:  w_alu_result = w_op_a & w_alu_b;
          F_OR:   w_alu_result = w_op_a | w_alu_b;
          F_XOR:  w_alu_result = w_op_a ^ w_alu_b;
          F_NOR:  w_alu_result = ~(w_op_a | w_alu_b);
          F_SLT:  w_alu_result = {{(NB_DATA-1){1'b0}}, ($signed(w_op_a) < $signed(w_alu_b))};
          F_SLTU: w_alu_result = {{(NB_DATA-1){1'b0}}, (w_op_a < w_alu_b)};
          F_SLL:  w_alu_result = w_alu_b << w_shamt;
          F_SRL:  w_alu_result = w_alu_b >> w_shamt;
          F_SRA:  w_alu_result = NB_DATA'($signed(w_alu_b) >>> w_shamt);
          F_MFHI: w_alu_result = r_hi;
          F_MFLO: w_alu_result = r_lo;
          default: w_alu_result = '0;
        endcase
      end
    endcase
  end

  assign w_is_mdu    = (w_alu_op == 2'b10) && (w_funct[5:2] == 4'b0110);
  assign w_mdu_start = (r_state == ST_IDLE) && bus.i_valid && !bus.i_flush && w_is_mdu;
  assign w_stall     = w_mdu_start || (r_state == ST_BUSY);
  assign w_live      = bus.i_valid && !bus.i_flush && !w_stall;

  // Iteration runs on magnitudes; signs are reapplied in DONE
  assign w_signed_in = ~w_funct[0];
  assign w_neg_a_in  = w_signed_in & w_op_a[NB_DATA-1];
  assign w_neg_b_in  = w_signed_in & w_fwd_b[NB_DATA-1];
  assign w_mag_a     = w_neg_a_in ? -w_op_a : w_op_a;
  assign w_mag_b     = w_neg_b_in ? -w_fwd_b : w_fwd_b;

  assign w_mul_sum  = {1'b0, r_prod[2*NB_DATA-1:NB_DATA]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
  assign w_mul_next = {w_mul_sum, r_prod[NB_DATA-1:1]};
  assign w_rem_sh   = {r_prod[2*NB_DATA-1:NB_DATA], r_prod[NB_DATA-1]};
  assign w_div_ge   = w_rem_sh >= {1'b0, r_mcand};
  assign w_div_diff = w_rem_sh - {1'b0, r_mcand};
  assign w_div_next = {(w_div_ge ? w_div_diff[NB_DATA-1:0] : w_rem_sh[NB_DATA-1:0]),
                       r_prod[NB_DATA-2:0], w_div_ge};

  assign w_neg_res  = r_md_signed & (r_neg_a ^ r_neg_b);
  assign w_prod_fin = w_neg_res ? -r_prod : r_prod;
  assign w_quot_fin = w_neg_res ? -r_prod[NB_DATA-1:0] : r_prod[NB_DATA-1:0];
  assign w_rem_fin  = (r_md_signed & r_neg_a) ? -r_prod[2*NB_DATA-1:NB_DATA]
                                              : r_prod[2*NB_DATA-1:NB_DATA];

  always_comb begin
    w_hi_new = w_prod_fin[2*NB_DATA-1:NB_DATA];
    w_lo_new = w_prod_fin[NB_DATA-1:0];
    if (r_md_div) begin
      w_hi_new = r_b_zero ? r_raw_a : w_rem_fin;
      w_lo_new = r_b_zero ? '1      : w_quot_fin;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state     <= ST_IDLE;
      r_count     <= '0;
      r_prod      <= '0;
      r_mcand     <= '0;
      r_raw_a     <= '0;
      r_md_div    <= 1'b0;
      r_md_signed <= 1'b0;
      r_neg_a     <= 1'b0;
      r_neg_b     <= 1'b0;
      r_b_zero    <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_h_pc      <= '0;
      r_h_rd2     <= '0;
      r_h_wreg    <= '0;
      r_h_ctrl    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_mdu_start) begin
            r_state     <= ST_BUSY;
            r_count     <= '0;
            r_prod      <= {{NB_DATA{1'b0}}, w_mag_a};
            r_mcand     <= w_mag_b;
            r_raw_a     <= w_op_a;
            r_md_div    <= w_funct[1];
            r_md_signed <= w_signed_in;
            r_neg_a     <= w_neg_a_in;
            r_neg_b     <= w_neg_b_in;
            r_b_zero    <= (w_fwd_b == '0);
            r_h_pc      <= bus.i_PC;
            r_h_rd2     <= w_fwd_b;
            r_h_wreg    <= w_write_reg;
            r_h_ctrl    <= w_ctrl_mwb;
          end
        end
        ST_BUSY: begin
          if (bus.i_flush) begin
            r_state <= ST_IDLE;
          end else begin
            r_prod  <= r_md_div ? w_div_next : w_mul_next;
            r_count <= r_count + 1'b1;
            if (r_count == LAST_STEP) r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          // A flush arriving in DONE kills the op before it reaches HI/LO
          if (!bus.i_flush) begin
            r_hi <= w_hi_new;
            r_lo <= w_lo_new;
          end
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_valid  <= 1'b0;
      r_pc     <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_rd2    <= '0;
      r_wreg   <= '0;
      r_ctrl   <= '0;
    end else if (r_state == ST_DONE) begin
      r_valid  <= !bus.i_flush;
      r_ctrl   <= bus.i_flush ? '0 : r_h_ctrl;
      r_pc     <= r_h_pc;
      r_result <= '0;
      r_zero   <= 1'b1;
      r_rd2    <= r_h_rd2;
      r_wreg   <= r_h_wreg;
    end else begin
      r_valid  <= w_live;
      r_ctrl   <= w_live ? w_ctrl_mwb : '0;
      r_pc     <= bus.i_PC;
      r_result <= w_alu_result;
      r_zero   <= (w_alu_result == '0);
      r_rd2    <= w_fwd_b;
      r_wreg   <= w_write_reg;
    end
  end

  assign bus.o_stall       = w_stall;
  assign bus.o_valid       = r_valid;
  assign bus.o_PC          = r_pc;
  assign bus.o_ALU_result  = r_result;
  assign bus.o_ALU_zero    = r_zero;
  assign bus.o_read_data_2 = r_rd2;
  assign bus.o_write_reg   = r_wreg;
  assign bus.o_control     = r_ctrl;
  assign bus.o_hi          = r_hi;
  assign bus.o_lo          = r_lo;
endmodule

// File: tb/tb_seg_execute_mdu.sv
// Randomized bench for seg_execute_mdu against an arithmetic reference model of the
// ALU, forwarding and MULT/DIV results, plus directed reset, flush and corner cases.
module tb_seg_execute_mdu;
  localparam int NB_ADDR = 32;
  localparam int NB_DATA = 32;
  localparam int NB_REG  = 5;

  typedef struct packed {
    logic        valid;
    logic        flush;
    logic [1:0]  op;
    logic        src;
    logic        rdst;
    logic [4:0]  mwb;
    logic [31:0] pc;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] imm;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [31:0] memd;
    logic [31:0] wbd;
    logic [4:0]  rt_idx;
    logic [4:0]  rd_idx;
  } vec_t;

  logic i_clk = 1'b0;
  logic i_rst;
  int   n_vec = 0;
  int   n_err = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always #5 i_clk = ~i_clk;

  seg_execute_mdu_if #(.NB_ADDR(NB_ADDR), .NB_DATA(NB_DATA), .NB_REG(NB_REG)) bus ();

  seg_execute_mdu #(.NB_ADDR(NB_ADDR), .NB_DATA(NB_DATA), .NB_REG(NB_REG)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic apply(input vec_t v);
    bus.i_valid        = v.valid;
    bus.i_flush        = v.flush;
    bus.i_PC           = v.pc;
    bus.i_read_data_1  = v.rs;
    bus.i_read_data_2  = v.rt;
    bus.i_imm          = v.imm;
    bus.i_rt           = v.rt_idx;
    bus.i_rd           = v.rd_idx;
    bus.i_control      = {v.src, v.op, v.rdst, v.mwb};
    bus.i_fwd_a        = v.fa;
    bus.i_fwd_b        = v.fb;
    bus.i_fwd_mem_data = v.memd;
    bus.i_fwd_wb_data  = v.wbd;
  endtask

  function automatic logic [31:0] fwd(input logic [1:0] s, input logic [31:0] rf, memd, wbd);
    if (s == 2'b01) return wbd;
    if (s == 2'b10) return memd;
    return rf;
  endfunction

  function automatic logic [31:0] model_alu(input logic [1:0] op, input logic [5:0] f,
                                            input logic [4:0] sh, input logic [31:0] a, b);
    case (op)
      2'b00: return a + b;
      2'b01: return a - b;
      2'b11: return a | b;
      default: case (f)
        6'h20, 6'h21: return a + b;
        6'h22, 6'h23: return a - b;
        6'h24: return a & b;
        6'h25: return a | b;
        6'h26: return a ^ b;
        6'h27: return ~(a | b);
        6'h2a: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        6'h2b: return (a < b) ? 32'd1 : 32'd0;
        6'h00: return b << sh;
        6'h02: return b >> sh;
        6'h03: return 32'($signed(b) >>> sh);
        6'h10: return m_hi;
        6'h12: return m_lo;
        default: return 32'd0;
      endcase
    endcase
  endfunction

  // {HI, LO} from plain wide arithmetic
  function automatic logic [63:0] model_mdu(input logic [5:0] f, input logic [31:0] a, b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f)
      6'h18: return 64'(sa * sb);
      6'h19: return {32'd0, a} * {32'd0, b};
      6'h1a: if (b == 0) return {a, 32'hFFFF_FFFF};
             else return {32'(sa % sb), 32'(sa / sb)};
      default: if (b == 0) return {a, 32'hFFFF_FFFF};
               else return {a % b, a / b};
    endcase
  endfunction

  function automatic vec_t rand_base();
    vec_t v;
    v        = '0;
    v.valid  = 1'b1;
    v.mwb    = 5'($urandom);
    v.pc     = $urandom;
    v.rs     = $urandom;
    v.rt     = $urandom;
    v.imm    = $urandom;
    v.memd   = $urandom;
    v.wbd    = $urandom;
    v.rt_idx = 5'($urandom);
    v.rd_idx = 5'($urandom);
    return v;
  endfunction

  function automatic vec_t rtype(input logic [5:0] f, input logic [31:0] a, b);
    vec_t v;
    v          = rand_base();
    v.op       = 2'b10;
    v.rdst     = 1'b1;
    v.rs       = a;
    v.rt       = b;
    v.imm[5:0] = f;
    return v;
  endfunction

  task automatic alu_vec(input string tag, input vec_t v);
    logic [31:0] a, b, alu_b, exp;
    logic        live;
    a     = fwd(v.fa, v.rs, v.memd, v.wbd);
    b     = fwd(v.fb, v.rt, v.memd, v.wbd);
    alu_b = v.src ? v.imm : b;
    exp   = model_alu(v.op, v.imm[5:0], v.imm[10:6], a, alu_b);
    live  = v.valid && !v.flush;
    apply(v);
    #1;
    check({tag, "_stall"}, bus.o_stall, 1'b0);
    tick();
    check({tag, "_valid"}, bus.o_valid, live);
    check({tag, "_ctrl"}, bus.o_control, live ? v.mwb : 5'd0);
    if (live) begin
      check({tag, "_result"}, bus.o_ALU_result, exp);
      check({tag, "_zero"}, bus.o_ALU_zero, exp == 32'd0);
      check({tag, "_rd2"}, bus.o_read_data_2, b);
      check({tag, "_wreg"}, bus.o_write_reg, v.rdst ? v.rd_idx : v.rt_idx);
      check({tag, "_pc"}, bus.o_PC, v.pc);
    end
  endtask

  task automatic mdu_vec(input string tag, input logic [5:0] f, input logic [31:0] a, b);
    vec_t        v;
    logic [63:0] exp;
    int          cyc;
    v   = rtype(f, a, b);
    exp = model_mdu(f, a, b);
    apply(v);
    #1;
    check({tag, "_start_stall"}, bus.o_stall, 1'b1);
    cyc = 0;
    while (bus.o_stall === 1'b1 && cyc < 200) begin
      tick();
      cyc++;
      if (cyc == 1) check({tag, "_bubble"}, bus.o_valid, 1'b0);
    end
    check({tag, "_stall_len"}, cyc, 33);
    tick();
    v.valid = 1'b0;
    apply(v);
    check({tag, "_retire_valid"}, bus.o_valid, 1'b1);
    check({tag, "_retire_ctrl"}, bus.o_control, v.mwb);
    check({tag, "_retire_wreg"}, bus.o_write_reg, v.rd_idx);
    check({tag, "_retire_pc"}, bus.o_PC, v.pc);
    check({tag, "_hi"}, bus.o_hi, exp[63:32]);
    check({tag, "_lo"}, bus.o_lo, exp[31:0]);
    m_hi = exp[63:32];
    m_lo = exp[31:0];
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"}, bus.o_stall, 1'b0);
    check({tag, "_valid"}, bus.o_valid, 1'b0);
    check({tag, "_pc"}, bus.o_PC, 32'd0);
    check({tag, "_result"}, bus.o_ALU_result, 32'd0);
    check({tag, "_zero"}, bus.o_ALU_zero, 1'b0);
    check({tag, "_rd2"}, bus.o_read_data_2, 32'd0);
    check({tag, "_wreg"}, bus.o_write_reg, 5'd0);
    check({tag, "_ctrl"}, bus.o_control, 5'd0);
    check({tag, "_hi"}, bus.o_hi, 32'd0);
    check({tag, "_lo"}, bus.o_lo, 32'd0);
  endtask

  initial begin
    vec_t        v;
    logic [5:0]  alu_functs [16];
    logic [31:0] hi_before, lo_before;

    alu_functs = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                   6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h10, 6'h12, 6'h3f};

    // Reset held two cycles
    v = '0;
    apply(v);
    i_rst = 1'b0;
    tick();
    tick();
    i_rst = 1'b1;
    #1;
    check_all_zero("reset");

    // Directed single-cycle cases
    v = rtype(6'h22, 32'd5, 32'd7);
    alu_vec("sub", v);
    check("sub_const", bus.o_ALU_result, 32'hFFFF_FFFE);
    check("sub_zero_const", bus.o_ALU_zero, 1'b0);
    v = rtype(6'h2a, 32'd5, 32'd7);
    alu_vec("slt", v);
    check("slt_const", bus.o_ALU_result, 32'd1);
    v = rtype(6'h2b, 32'hFFFF_FFFF, 32'd1);
    alu_vec("sltu", v);
    check("sltu_const", bus.o_ALU_result, 32'd0);

    v      = rtype(6'h20, $urandom, $urandom);
    v.fa   = 2'b10;
    v.memd = 32'h10;
    v.fb   = 2'b01;
    v.wbd  = 32'h22;
    alu_vec("fwd", v);
    check("fwd_const", bus.o_ALU_result, 32'h32);
    check("fwd_rd2_const", bus.o_read_data_2, 32'h22);

    v      = rand_base();
    v.op   = 2'b01;
    v.rt   = v.rs;
    alu_vec("beq_eq", v);
    check("beq_zero_const", bus.o_ALU_zero, 1'b1);

    v       = rtype(6'h03, 32'd0, 32'h8000_0000);
    v.imm[10:6] = 5'd4;
    alu_vec("sra", v);
    check("sra_const", bus.o_ALU_result, 32'hF800_0000);

    v       = rtype(6'h20, 32'd1, 32'd2);
    v.flush = 1'b1;
    alu_vec("flush_alu", v);

    // MDU directed cases
    mdu_vec("mult_neg", 6'h18, 32'hFFFF_FFFE, 32'd3);
    check("mult_hi_const", bus.o_hi, 32'hFFFF_FFFF);
    check("mult_lo_const", bus.o_lo, 32'hFFFF_FFFA);
    v = rtype(6'h10, $urandom, $urandom);
    alu_vec("mfhi", v);
    check("mfhi_const", bus.o_ALU_result, 32'hFFFF_FFFF);

    mdu_vec("div_neg", 6'h1a, 32'hFFFF_FFF9, 32'd2);
    check("div_lo_const", bus.o_lo, 32'hFFFF_FFFD);
    check("div_hi_const", bus.o_hi, 32'hFFFF_FFFF);
    mdu_vec("divu_zero", 6'h1b, 32'd9, 32'd0);
    check("divu0_lo_const", bus.o_lo, 32'hFFFF_FFFF);
    check("divu0_hi_const", bus.o_hi, 32'd9);
    mdu_vec("div_zero_neg", 6'h1a, 32'hFFFF_FFF9, 32'd0);
    mdu_vec("div_min", 6'h1a, 32'h8000_0000, 32'hFFFF_FFFF);
    check("divmin_lo_const", bus.o_lo, 32'h8000_0000);
    check("divmin_hi_const", bus.o_hi, 32'd0);
    mdu_vec("multu_max", 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    v = rtype(6'h12, $urandom, $urandom);
    alu_vec("mflo", v);

    // Random MDU ops
    for (int i = 0; i < 12; i++) begin
      logic [5:0] f;
      f = 6'h18 + 6'($urandom_range(0, 3));
      mdu_vec("mdu_rand", f, $urandom, (i % 4 == 3) ? 32'($urandom_range(0, 15)) : $urandom);
    end

    // Flush in the tenth BUSY cycle
    hi_before = m_hi;
    lo_before = m_lo;
    v = rtype(6'h18, $urandom, $urandom);
    apply(v);
    #1;
    check("flush_start_stall", bus.o_stall, 1'b1);
    for (int i = 0; i < 10; i++) tick();
    check("flush_busy_stall", bus.o_stall, 1'b1);
    bus.i_flush = 1'b1;
    tick();
    bus.i_flush = 1'b0;
    bus.i_valid = 1'b0;
    #1;
    check("flush_stall_drop", bus.o_stall, 1'b0);
    check("flush_valid", bus.o_valid, 1'b0);
    check("flush_hi", bus.o_hi, hi_before);
    check("flush_lo", bus.o_lo, lo_before);
    tick();
    check("flush_hi_later", bus.o_hi, hi_before);
    check("flush_lo_later", bus.o_lo, lo_before);

    // Reset pulse in BUSY cycle 5
    v = rtype(6'h1a, $urandom, 32'd3);
    apply(v);
    #1;
    for (int i = 0; i < 5; i++) tick();
    check("rst_mid_busy_stall", bus.o_stall, 1'b1);
    bus.i_valid = 1'b0;
    i_rst = 1'b0;
    #1;
    check_all_zero("rst_mid");
    tick();
    i_rst = 1'b1;
    m_hi = '0;
    m_lo = '0;
    v = rtype(6'h10, $urandom, $urandom);
    alu_vec("rst_mfhi", v);
    mdu_vec("post_rst_mult", 6'h18, $urandom, $urandom);

    // Random single-cycle traffic
    for (int i = 0; i < 300; i++) begin
      v       = rand_base();
      v.op    = 2'($urandom);
      v.src   = (v.op == 2'b10) ? 1'b0 : 1'($urandom);
      v.rdst  = 1'($urandom);
      v.fa    = 2'($urandom);
      v.fb    = 2'($urandom);
      v.valid = ($urandom_range(0, 7) != 0);
      v.flush = ($urandom_range(0, 9) == 0);
      v.imm[5:0] = alu_functs[$urandom_range(0, 15)];
      if ($urandom_range(0, 7) == 0) v.rt = v.rs;
      alu_vec("rand", v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/seg_execute_mdu.md
Name: seg_execute_mdu

Overview:
Parametrised next-generation EX pipeline stage for the MIPS core: operand forwarding muxes, single-cycle ALU, iterative multiply/divide unit with HI/LO registers, and the EX/MEM pipeline register. It sits between the ID/EX register and seg_memory. It raises a stall to the hazard unit while a multi-cycle MULT/DIV is in flight, and it supports flush.

Parameters:
NB_ADDR, 32, PC width
NB_DATA, 32, datapath width (even, >=8); the MDU iterates NB_DATA cycles
NB_REG, 5, register-index width
NB_CTRL_WB, 2, WB control field width
NB_CTRL_M, 3, MEM control field width
NB_CTRL_EX, 4, EX control field width {ALUSrc, ALUOp[1:0], RegDst}, in the MSBs of i_control

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous, active-low reset
i_valid  in  1  ID/EX holds a real instruction
i_flush  in  1  kill the current instruction or the in-flight MDU op
i_PC  in  NB_ADDR  PC+4 of the instruction
i_read_data_1  in  NB_DATA  rs value
i_read_data_2  in  NB_DATA  rt value
i_imm  in  NB_DATA  sign-extended immediate; bits [5:0] are funct
i_rt  in  NB_REG  rt index
i_rd  in  NB_REG  rd index
i_control  in  NB_CTRL_EX+NB_CTRL_M+NB_CTRL_WB  {EX,M,WB}
i_fwd_a, i_fwd_b  in  2  00 = reg file, 01 = WB data, 10 = MEM data, 11 = reg file
i_fwd_mem_data  in  NB_DATA  forwarded EX/MEM result
i_fwd_wb_data  in  NB_DATA  forwarded MEM/WB result
o_stall  out  1  freeze PC, IF/ID and ID/EX
o_valid  out  1  EX/MEM holds a real instruction
o_PC  out  NB_ADDR  registered i_PC
o_ALU_result  out  NB_DATA  registered result
o_ALU_zero  out  1  registered (result == 0)
o_read_data_2  out  NB_DATA  registered forwarded B operand, used as store data
o_write_reg  out  NB_REG  registered RegDst ? rd : rt
o_control  out  NB_CTRL_M+NB_CTRL_WB  registered {M,WB}
o_hi, o_lo  out  NB_DATA  HI/LO architectural registers

Behaviour:
- Reset (i_rst=0, asynchronous): all outputs, HI, LO, MDU state and counter are 0; FSM goes to IDLE.
- Operand A is fwd_a-selected. Forwarded B (fwd_b-selected) goes to o_read_data_2. The ALU B operand is ALUSrc ? i_imm : forwarded B.
- ALUOp decode:
  - 00 = ADD (lw/sw).
  - 01 = SUB (beq).
  - 11 = OR (immediate logical).
  - 10 = funct decode:
    - 100000/100001 ADD
    - 100010/100011 SUB
    - 100100 AND
    - 100101 OR
    - 100110 XOR
    - 100111 NOR
    - 101010 SLT (signed)
    - 101011 SLTU
    - 000000 SLL by i_imm[10:6]
    - 000010 SRL
    - 000011 SRA
    - 010000 MFHI
    - 010010 MFLO
    - 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU
    - any other funct: result 0
- Arithmetic wraps modulo 2^NB_DATA; no overflow trap.
- Single-cycle ops: result registered at the next rising edge (latency 1). o_valid = i_valid & ~i_flush.
- MDU FSM, states IDLE, BUSY, DONE:
  - IDLE -> BUSY: on i_valid & ~i_flush & MDU funct. Latch operands, counter = 0, o_stall = 1 combinationally in that same cycle. EX/MEM loads a bubble (o_valid=0, o_control=0).
  - BUSY: one shift-add (mul) or restoring-subtract (div) step per cycle on magnitudes. Counter increments; o_stall = 1; bubbles keep entering EX/MEM.
  - BUSY -> DONE: when counter == NB_DATA-1.
  - DONE: apply signs. MULT: {HI,LO} = 2*NB_DATA-bit product. DIV: LO = quotient, HI = remainder (remainder takes the sign of the dividend). Write HI/LO; o_stall = 0. The held instruction retires to EX/MEM with o_valid=1 and its own control (WB normally 0).
  - DONE -> IDLE: next cycle.
  - Total stall: NB_DATA+1 cycles.
- Divide by zero: LO = all ones, HI = dividend; no exception; same latency.
- Signed corner: DIV of -2^(NB_DATA-1) by -1 gives LO = -2^(NB_DATA-1), HI = 0.
- Flush while BUSY: abort, HI/LO unchanged, FSM -> IDLE at the next edge, o_stall drops the next cycle.
- i_flush with a single-cycle op: a bubble is loaded.
- MFHI/MFLO held behind a busy MDU reads the post-DONE HI/LO, because the stall holds it upstream.
- Reset mid-operation: immediate return to IDLE; HI/LO = 0.
- i_valid=0 cycles load bubbles and never start the MDU.

Test Plan:
- Reset: hold i_rst=0 two cycles, then release → every output and o_hi/o_lo equal 0; o_stall=0.
- ALU ops:
  - ALUOp=10, funct 100010, rs=5, rt=7 → o_ALU_result=0xFFFFFFFE, o_ALU_zero=0 one cycle later.
  - funct 101010 → 1.
  - funct 101011 with rs=0xFFFFFFFF, rt=1 → 0.
- Forwarding: fwd_a=10, i_fwd_mem_data=0x10; fwd_b=01, i_fwd_wb_data=0x22; funct 100000 → result 0x32, o_read_data_2=0x22.
- MULT then MFHI: MULT rs=0xFFFFFFFE (-2), rt=3 → o_stall high 33 cycles, then o_hi=0xFFFFFFFF, o_lo=0xFFFFFFFA; the following MFHI writes 0xFFFFFFFF.
- Divide:
  - DIV rs=-7, rt=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU rs=9, rt=0 → LO=0xFFFFFFFF, HI=9.
- Flush/reset mid-MDU: assert i_flush in BUSY cycle 10 → HI/LO unchanged, o_stall=0 next cycle; repeat with i_rst pulsed low in cycle 5 → all outputs 0, FSM IDLE.
